// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants for the receive path and its byte FIFO.
package uart_pkg;
   localparam int UART_BYTE_W = 8;
   localparam int UART_DEPTH_LOG2 = 4;
   localparam int UART_CLK_HZ = 25_000_000;
   localparam int UART_BAUD = 9600;
   localparam int UART_CYC_PER_BIT = UART_CLK_HZ / UART_BAUD;
   // four 10-bit character times of idle line
   localparam logic [19:0] UART_TMO_CYCLES = 20'(UART_CYC_PER_BIT * 10 * 4);
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port byte memory, registered read port.
module uart_fifo_mem import uart_pkg::*; #(
   parameter int AW = UART_DEPTH_LOG2
) (
   input  logic                   clk_i,
   input  logic                   n_rst,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [UART_BYTE_W-1:0] wdata,
   input  logic                   re,
   input  logic [AW-1:0]          raddr,
   output logic [UART_BYTE_W-1:0] rdata
);
   logic [UART_BYTE_W-1:0] mem [2**AW];
   always_ff @(posedge clk_i)
      if (we) mem[waddr] <= wdata;
   // read-before-write: a full-FIFO read+write on the same slot returns the old byte
   always_ff @(posedge clk_i or negedge n_rst)
      if (!n_rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures UART rx bytes on done rising edge into a FIFO with sticky overrun.
// Optional idle timeout flag built only when UART_RX_FIFO_TMO_EN is defined.
module uart_rx_fifo import uart_pkg::*; #(
   parameter int          DEPTH_LOG2 = UART_DEPTH_LOG2,
   parameter logic [19:0] TMO_CYCLES = UART_TMO_CYCLES
) (
   input  logic                   clk_i,
   input  logic                   n_rst,
   input  logic [UART_BYTE_W-1:0] rx_data_i,
   input  logic                   rx_done_i,
   input  logic                   rd_en_i,
   output logic [UART_BYTE_W-1:0] rd_data_o,
   output logic                   rd_valid_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [DEPTH_LOG2:0]    count_o,
   output logic                   ovr_o,
   input  logic                   ovr_clr_i,
   output logic                   tmo_o
);
   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
   logic rx_done_d, wr, rd_ok, wr_ok;
   assign empty_o = wr_ptr == rd_ptr;
   assign full_o = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign count_o = wr_ptr - rd_ptr;
   assign wr = rx_done_i & ~rx_done_d;
   assign rd_ok = rd_en_i & ~empty_o;
   assign wr_ok = wr & (~full_o | rd_ok);
   // rx_done_d resets high so a done level held through reset is not a new byte
   always_ff @(posedge clk_i or negedge n_rst)
      if (!n_rst) begin
         rx_done_d <= 1'b1;
         wr_ptr <= '0;
         rd_ptr <= '0;
         rd_valid_o <= 1'b0;
         ovr_o <= 1'b0;
      end else begin
         rx_done_d <= rx_done_i;
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         rd_valid_o <= rd_ok;
         ovr_o <= (wr & ~wr_ok) | (ovr_o & ~ovr_clr_i);
      end
   uart_fifo_mem #(.AW(DEPTH_LOG2)) u_mem (
      .clk_i(clk_i),
      .n_rst(n_rst),
      .we(wr_ok),
      .waddr(wr_ptr[DEPTH_LOG2-1:0]),
      .wdata(rx_data_i),
      .re(rd_ok),
      .raddr(rd_ptr[DEPTH_LOG2-1:0]),
      .rdata(rd_data_o)
   );
`ifdef UART_RX_FIFO_TMO_EN
   logic [19:0] tmo_cnt;
   always_ff @(posedge clk_i or negedge n_rst)
      if (!n_rst) tmo_cnt <= '0;
      else if (wr | rd_ok | empty_o) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_CYCLES) tmo_cnt <= tmo_cnt + 1'b1;
   assign tmo_o = tmo_cnt == TMO_CYCLES;
`else
   logic unused_tmo;
   assign unused_tmo = ^TMO_CYCLES;
   assign tmo_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized self-checking bench for uart_rx_fifo against a queue model.
module tb_uart_rx_fifo;
   localparam int DL = 4;
   localparam int DEPTH = 16;
   localparam int TMO = 100;
   logic clk_i = 0, n_rst = 0;
   logic [7:0] rx_data_i = 0;
   logic rx_done_i = 0, rd_en_i = 0, ovr_clr_i = 0;
   logic [7:0] rd_data_o;
   logic rd_valid_o, empty_o, full_o, ovr_o, tmo_o;
   logic [DL:0] count_o;
   int n_chk = 0, n_pass = 0;

   uart_rx_fifo #(.DEPTH_LOG2(DL), .TMO_CYCLES(20'(TMO))) dut (
      .clk_i(clk_i), .n_rst(n_rst), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
      .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
      .empty_o(empty_o), .full_o(full_o), .count_o(count_o), .ovr_o(ovr_o),
      .ovr_clr_i(ovr_clr_i), .tmo_o(tmo_o)
   );

   always #5 clk_i = ~clk_i;

   // behavioural model: byte queue, sticky flag, idle cycle count
   logic [7:0] m_q[$];
   bit m_prev = 1, m_ovr = 0, m_valid = 0;
   logic [7:0] m_data = 0;
   int m_idle = 0;
   always @(posedge clk_i or negedge n_rst) begin
      if (!n_rst) begin
         m_q.delete(); m_prev = 1; m_ovr = 0; m_valid = 0; m_data = 0; m_idle = 0;
      end else begin
         bit w, r, drop;
         w = rx_done_i && !m_prev;
         m_prev = rx_done_i;
         r = rd_en_i && m_q.size() > 0;
         m_valid = r;
         if (r) m_data = m_q.pop_front();
         drop = 0;
         if (w) begin
            if (m_q.size() < DEPTH) m_q.push_back(rx_data_i);
            else drop = 1;
         end
         m_ovr = drop ? 1'b1 : (ovr_clr_i ? 1'b0 : m_ovr);
         if (w || r || m_q.size() == 0) m_idle = 0;
         else if (m_idle < TMO) m_idle++;
      end
   end

   function automatic bit exp_tmo();
`ifdef UART_RX_FIFO_TMO_EN
      return m_idle == TMO;
`else
      return 1'b0;
`endif
   endfunction

   task automatic send_byte(input logic [7:0] d, input int hold);
      @(negedge clk_i);
      rx_data_i = d; rx_done_i = 1;
      repeat (hold) @(negedge clk_i);
      rx_done_i = 0;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rx_done_i = 1; n_rst = 0;
      repeat (3) @(negedge clk_i);
      n_rst = 1;
      repeat (3000) @(negedge clk_i);
      n_chk++; if (count_o !== 0) $display("FAIL reset_count got %0d want 0", count_o); else n_pass++;
      n_chk++; if (empty_o !== 1) $display("FAIL reset_empty got %b want 1", empty_o); else n_pass++;
      n_chk++; if (full_o !== 0 || ovr_o !== 0 || tmo_o !== 0) $display("FAIL reset_flags got full=%b ovr=%b tmo=%b want 0", full_o, ovr_o, tmo_o); else n_pass++;
      n_chk++; if (rd_valid_o !== 0 || rd_data_o !== 0) $display("FAIL reset_rd got v=%b d=%h want 0/00", rd_valid_o, rd_data_o); else n_pass++;
      rx_done_i = 0;
      @(negedge clk_i);
   endtask

   task automatic test_basic();
      logic [7:0] bytes[3] = '{8'h41, 8'h42, 8'h43};
      foreach (bytes[i]) send_byte(bytes[i], 500);
      n_chk++; if (count_o !== 3) $display("FAIL basic_count got %0d want 3", count_o); else n_pass++;
      foreach (bytes[i]) begin
         rd_en_i = 1;
         @(negedge clk_i);
         rd_en_i = 0;
         n_chk++; if (rd_valid_o !== 1 || rd_data_o !== bytes[i]) $display("FAIL basic_read%0d got v=%b d=%h want 1/%h", i, rd_valid_o, rd_data_o, bytes[i]); else n_pass++;
         @(negedge clk_i);
         n_chk++; if (rd_valid_o !== 0) $display("FAIL basic_pulse%0d got v=%b want 0", i, rd_valid_o); else n_pass++;
      end
      n_chk++; if (empty_o !== 1) $display("FAIL basic_empty got %b want 1", empty_o); else n_pass++;
   endtask

   task automatic test_overrun();
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i), $urandom_range(1, 5));
      send_byte(8'hFF, 3);
      n_chk++; if (full_o !== 1 || ovr_o !== 1 || count_o !== 16) $display("FAIL ovr_state got full=%b ovr=%b cnt=%0d want 1/1/16", full_o, ovr_o, count_o); else n_pass++;
      rd_en_i = 1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk_i);
         n_chk++; if (rd_valid_o !== 1 || rd_data_o !== 8'(i)) $display("FAIL ovr_read%0d got v=%b d=%h want 1/%h", i, rd_valid_o, rd_data_o, 8'(i)); else n_pass++;
      end
      rd_en_i = 0;
      @(negedge clk_i);
      n_chk++; if (empty_o !== 1 || rd_valid_o !== 0 || ovr_o !== 1) $display("FAIL ovr_drained got e=%b v=%b ovr=%b want 1/0/1", empty_o, rd_valid_o, ovr_o); else n_pass++;
      ovr_clr_i = 1;
      @(negedge clk_i);
      ovr_clr_i = 0;
      n_chk++; if (ovr_o !== 0) $display("FAIL ovr_clr got %b want 0", ovr_o); else n_pass++;
   endtask

   task automatic test_full_simul();
      logic [7:0] head;
      for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1);
      head = m_q[0];
      rx_data_i = 8'hA5; rx_done_i = 1; rd_en_i = 1;
      @(negedge clk_i);
      rd_en_i = 0;
      n_chk++; if (ovr_o !== 0 || count_o !== 16) $display("FAIL simul_state got ovr=%b cnt=%0d want 0/16", ovr_o, count_o); else n_pass++;
      n_chk++; if (rd_valid_o !== 1 || rd_data_o !== head) $display("FAIL simul_read got v=%b d=%h want 1/%h", rd_valid_o, rd_data_o, head); else n_pass++;
      rx_done_i = 0;
      @(negedge clk_i);
      rx_data_i = 8'h11; rx_done_i = 1; ovr_clr_i = 1;
      @(negedge clk_i);
      ovr_clr_i = 0; rx_done_i = 0;
      n_chk++; if (ovr_o !== 1) $display("FAIL set_beats_clr got %b want 1", ovr_o); else n_pass++;
      ovr_clr_i = 1;
      @(negedge clk_i);
      ovr_clr_i = 0;
      n_chk++; if (ovr_o !== 0) $display("FAIL clr_after got %b want 0", ovr_o); else n_pass++;
      rd_en_i = 1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk_i);
         n_chk++; if (rd_valid_o !== m_valid || rd_data_o !== m_data) $display("FAIL simul_drain%0d got v=%b d=%h want %b/%h", i, rd_valid_o, rd_data_o, m_valid, m_data); else n_pass++;
      end
      rd_en_i = 0;
      @(negedge clk_i);
      n_chk++; if (empty_o !== 1) $display("FAIL simul_empty got %b want 1", empty_o); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [7:0] prev;
      prev = rd_data_o;
      rd_en_i = 1;
      @(negedge clk_i);
      rd_en_i = 0;
      n_chk++; if (rd_valid_o !== 0 || rd_data_o !== prev) $display("FAIL empty_read got v=%b d=%h want 0/%h", rd_valid_o, rd_data_o, prev); else n_pass++;
      for (int c = 0; c < 400; c++) begin
         if (!rx_done_i) rx_data_i = 8'($urandom);
         rx_done_i = ($urandom_range(0, 2) != 0) ? ~rx_done_i : rx_done_i;
         rd_en_i = $urandom_range(0, 3) == 0;
         @(negedge clk_i);
         n_chk++;
         if (int'(count_o) != m_q.size() || empty_o !== (m_q.size() == 0) || full_o !== (m_q.size() == DEPTH) || ovr_o !== m_ovr)
            $display("FAIL wrap_state%0d got cnt=%0d e=%b f=%b ovr=%b want %0d/%b/%b/%b", c, count_o, empty_o, full_o, ovr_o, m_q.size(), m_q.size() == 0, m_q.size() == DEPTH, m_ovr);
         else n_pass++;
         n_chk++; if (rd_valid_o !== m_valid || rd_data_o !== m_data) $display("FAIL wrap_read%0d got v=%b d=%h want %b/%h", c, rd_valid_o, rd_data_o, m_valid, m_data); else n_pass++;
      end
      rx_done_i = 0; rd_en_i = 1;
      repeat (DEPTH + 2) @(negedge clk_i);
      rd_en_i = 0;
      ovr_clr_i = 1;
      @(negedge clk_i);
      ovr_clr_i = 0;
   endtask

   task automatic test_tmo();
      send_byte(8'h5A, 2);
      for (int c = 0; c < TMO + 20; c++) begin
         n_chk++; if (tmo_o !== exp_tmo()) $display("FAIL tmo_idle%0d got %b want %b", c, tmo_o, exp_tmo()); else n_pass++;
         @(negedge clk_i);
      end
`ifdef UART_RX_FIFO_TMO_EN
      n_chk++; if (tmo_o !== 1) $display("FAIL tmo_rise got %b want 1", tmo_o); else n_pass++;
`else
      n_chk++; if (tmo_o !== 0) $display("FAIL tmo_off got %b want 0", tmo_o); else n_pass++;
`endif
      rd_en_i = 1;
      @(negedge clk_i);
      rd_en_i = 0;
      n_chk++; if (tmo_o !== 0 || rd_data_o !== 8'h5A) $display("FAIL tmo_read got tmo=%b d=%h want 0/5a", tmo_o, rd_data_o); else n_pass++;
      repeat (TMO + 10) @(negedge clk_i);
      n_chk++; if (tmo_o !== 0 || empty_o !== 1) $display("FAIL tmo_empty got tmo=%b e=%b want 0/1", tmo_o, empty_o); else n_pass++;
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1);
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1);
      #2 n_rst = 0;
      #1;
      n_chk++; if (count_o !== 0 || empty_o !== 1 || full_o !== 0 || ovr_o !== 0 || tmo_o !== 0) $display("FAIL midrst got cnt=%0d e=%b f=%b ovr=%b tmo=%b want 0/1/0/0/0", count_o, empty_o, full_o, ovr_o, tmo_o); else n_pass++;
      @(negedge clk_i);
      n_rst = 1;
      rd_en_i = 1;
      @(negedge clk_i);
      rd_en_i = 0;
      n_chk++; if (rd_valid_o !== 0 || empty_o !== 1) $display("FAIL midrst_read got v=%b e=%b want 0/1", rd_valid_o, empty_o); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_full_simul();
      test_wrap();
      test_tmo();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
